sdram_write_master: RTL and testbench
=====================================

Name: sdram_write_master

Overview:
Avalon-MM write master that streams user data from an internal FIFO into SDRAM. It is the write-direction counterpart of the SDRAM read master in the system, and uses the same control/user split. The control side starts one burst-free transfer of control_write_length bytes at control_write_base. The user side pushes 16-bit words into the FIFO. The block sits between user logic and the SDRAM controller's Avalon slave port.

Parameters:
DATA_WIDTH, 16, word width of user data and master_writedata
BYTE_ENABLE_WIDTH, 2, DATA_WIDTH/8; also the address/length step per word
ADDRESS_WIDTH, 25, byte address width
LENGTH_WIDTH, 25, byte length width
FIFO_DEPTH, 32, FIFO words
FIFO_DEPTH_LOG2, 5, log2(FIFO_DEPTH)

Ports:
clk  in  1  single clock, all logic rising edge
reset  in  1  asynchronous, active-high reset
control_fixed_location  in  1  1 = every write goes to control_write_base
control_write_base  in  ADDRESS_WIDTH  start byte address, word aligned
control_write_length  in  LENGTH_WIDTH  bytes to write, multiple of BYTE_ENABLE_WIDTH
control_go  in  1  start request, sampled only in IDLE
control_done  out  1  level, high while IDLE
user_write_buffer  in  1  push user_buffer_input_data into FIFO
user_buffer_input_data  in  DATA_WIDTH  push data
user_buffer_full  out  1  FIFO holds FIFO_DEPTH words
master_address  out  ADDRESS_WIDTH  Avalon byte address
master_write  out  1  Avalon write request
master_byteenable  out  BYTE_ENABLE_WIDTH  always all ones
master_writedata  out  DATA_WIDTH  FIFO head word
master_waitrequest  in  1  Avalon slave stall

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, reset.
- Reset values:
  - state = IDLE; control_done = 1; master_write = 0; master_address = 0.
  - Remaining length = 0; FIFO count = 0 and pointers = 0; user_buffer_full = 0.
  - master_byteenable is constant all ones.
- States:
  - IDLE:
    - If control_go = 1 and control_write_length != 0: latch base into master_address, latch length, latch fixed_location; go to RUN.
    - control_done is 0 from the next cycle.
    - If control_go = 1 and length = 0: stay IDLE; done stays 1.
  - RUN:
    - control_go is ignored.
    - master_write = (fifo count != 0).
    - An accept is the cycle where master_write = 1 and master_waitrequest = 0. On accept:
      - pop the FIFO;
      - length -= BYTE_ENABLE_WIDTH;
      - master_address += BYTE_ENABLE_WIDTH, unless fixed_location, in which case it is unchanged.
    - When an accept makes length 0: next state is IDLE; control_done = 1 the following cycle; master_write = 0.
- Avalon hold rule: while master_write = 1 and master_waitrequest = 1, master_address and master_writedata are held stable. master_write never drops without an accept.
- FIFO:
  - Show-ahead: master_writedata is the head word, combinational from the RAM/register read.
  - A push is user_write_buffer = 1 and user_buffer_full = 0; pushes are accepted in any state.
  - A push while full is dropped; count and data are unchanged.
  - Push and pop in the same cycle: count is unchanged.
  - user_buffer_full is derived from registered count == FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a word pushed in cycle N can be presented on master_write in cycle N+1 at the earliest. Best-case throughput is 1 word/cycle.
- Leftover data: words pushed beyond the transfer length remain in the FIFO for the next transfer. The FIFO is not flushed on done.
- Reset mid-transfer: all state returns to the reset values immediately. FIFO contents are lost, and master_write drops asynchronously.
- Arithmetic: the address wraps modulo 2^ADDRESS_WIDTH. Behaviour for a length that is not a multiple of BYTE_ENABLE_WIDTH is undefined; the bench does not drive it.

Test Plan:
- Reset, then idle: after reset release -> control_done=1, master_write=0, user_buffer_full=0, master_byteenable=2'b11.
- Basic transfer: push 4 words 0x1111..0x4444, waitrequest=0, go with base 0x100, length 8 -> writes to 0x100, 0x102, 0x104, 0x106 with data in push order. control_done=1 one cycle after the 4th accept.
- Waitrequest stall: same transfer with waitrequest high for 3 cycles on the 2nd word -> address 0x102 and data 0x2222 held stable throughout the stall, exactly 4 accepts, no duplicated or skipped word.
- Fixed location plus underrun: go base 0x200, length 6, fixed=1, FIFO empty, then push 3 words spaced 5 cycles apart -> master_write=0 while the FIFO is empty; all 3 writes go to 0x200; then done.
- FIFO full: with no transfer running, push 33 words -> user_buffer_full=1 after the 32nd; the 33rd is dropped. A later 64-byte transfer writes exactly words 1..32.
- Edge cases:
  - go with length 0 -> done stays 1, no write.
  - go while in RUN -> ignored.
  - reset asserted mid-transfer after 2 of 4 accepts -> master_write=0 immediately, done=1, count=0.

Source files
------------

// File: rtl/sdram_write_master_if.sv
// Control, user-FIFO and Avalon-MM write-master signals of sdram_write_master.
interface sdram_write_master_if #(
    parameter int DATA_WIDTH        = 16,
    parameter int BYTE_ENABLE_WIDTH = 2,
    parameter int ADDRESS_WIDTH     = 25,
    parameter int LENGTH_WIDTH      = 25
);
    logic                         control_fixed_location;
    logic [ADDRESS_WIDTH-1:0]     control_write_base;
    logic [LENGTH_WIDTH-1:0]      control_write_length;
    logic                         control_go;
    logic                         control_done;
    logic                         user_write_buffer;
    logic [DATA_WIDTH-1:0]        user_buffer_input_data;
    logic                         user_buffer_full;
    logic [ADDRESS_WIDTH-1:0]     master_address;
    logic                         master_write;
    logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
    logic [DATA_WIDTH-1:0]        master_writedata;
    logic                         master_waitrequest;

    modport master (
        input  control_fixed_location, control_write_base,
        input  control_write_length, control_go,
        output control_done,
        input  user_write_buffer, user_buffer_input_data,
        output user_buffer_full,
        output master_address, master_write,
        output master_byteenable, master_writedata,
        input  master_waitrequest
    );

    modport slave (
        output control_fixed_location, control_write_base,
        output control_write_length, control_go,
        input  control_done,
        output user_write_buffer, user_buffer_input_data,
        input  user_buffer_full,
        input  master_address, master_write,
        input  master_byteenable, master_writedata,
        output master_waitrequest
    );
endinterface

// File: rtl/sdram_write_master.sv
// Avalon-MM write master draining a show-ahead user FIFO into SDRAM.
// One go request moves control_write_length bytes, one word per accept.
module sdram_write_master #(
    parameter int DATA_WIDTH        = 16,
    parameter int BYTE_ENABLE_WIDTH = 2,
    parameter int ADDRESS_WIDTH     = 25,
    parameter int LENGTH_WIDTH      = 25,
    parameter int FIFO_DEPTH        = 32,
    parameter int FIFO_DEPTH_LOG2   = 5
) (
    input  logic               clk,
    input  logic               reset,
    sdram_write_master_if.master bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [LENGTH_WIDTH-1:0]  LEN_STEP  = LENGTH_WIDTH'(BYTE_ENABLE_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL  = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);

    logic [0:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [LENGTH_WIDTH-1:0]  r_length;
    logic                     r_fixed;

    logic [DATA_WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;

    logic w_full;
    logic w_push;
    logic w_write;
    logic w_accept;
    logic w_last;

    assign w_full   = (r_count == CNT_FULL);
    assign w_push   = bus.user_write_buffer && !w_full;
    // Combinational on registered state so reset drops it at once.
    assign w_write  = (r_state == S_RUN) && (r_count != '0);
    assign w_accept = w_write && !bus.master_waitrequest;
    assign w_last   = (r_length == LEN_STEP);

    assign bus.control_done      = (r_state == S_IDLE);
    assign bus.user_buffer_full  = w_full;
    assign bus.master_address    = r_address;
    assign bus.master_write      = w_write;
    assign bus.master_byteenable = '1;
    assign bus.master_writedata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_address <= '0;
            r_length  <= '0;
            r_fixed   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.control_go && bus.control_write_length != '0) begin
                        r_state   <= S_RUN;
                        r_address <= bus.control_write_base;
                        r_length  <= bus.control_write_length;
                        r_fixed   <= bus.control_fixed_location;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_length <= r_length - LEN_STEP;
                        if (!r_fixed)
                            r_address <= r_address + ADDR_STEP;
                        if (w_last)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.user_buffer_input_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_accept)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_write_master.sv
// Directed and randomized bench for sdram_write_master with a queue-based
// reference model that predicts every Avalon write and status output.
module tb_sdram_write_master;
    localparam int DW    = 16;
    localparam int AW    = 25;
    localparam int LW    = 25;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_write_master_if bus ();

    sdram_write_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]    m_q [$];
    logic [AW-1:0]    m_addr = '0;
    logic [LW-1:0]    m_rem  = '0;
    logic             m_fix  = 1'b0;
    logic [AW+DW-1:0] rec [$];

    logic          stall_prev = 1'b0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: compare current outputs, then advance across the edge.
    always @(negedge clk) begin : model
        logic exp_w, acc, psh, idle;
        if (reset) begin
            m_q.delete();
            m_rem      = '0;
            m_addr     = '0;
            m_fix      = 1'b0;
            stall_prev = 1'b0;
        end else begin
            exp_w = (m_rem != 0) && (m_q.size() != 0);
            chk("done", 64'(bus.control_done), 64'(m_rem == 0));
            chk("write", 64'(bus.master_write), 64'(exp_w));
            chk("full", 64'(bus.user_buffer_full), 64'(m_q.size() == DEPTH));
            chk("byteen", 64'(bus.master_byteenable), 64'(2'b11));
            if (exp_w) begin
                chk("addr", 64'(bus.master_address), 64'(m_addr));
                chk("data", 64'(bus.master_writedata), 64'(m_q[0]));
            end
            if (stall_prev) begin
                chk("hold_w", 64'(bus.master_write), 64'(1'b1));
                chk("hold_a", 64'(bus.master_address), 64'(h_addr));
                chk("hold_d", 64'(bus.master_writedata), 64'(h_data));
            end
            stall_prev = bus.master_write && bus.master_waitrequest;
            h_addr     = bus.master_address;
            h_data     = bus.master_writedata;

            idle = (m_rem == 0);
            acc  = exp_w && !bus.master_waitrequest;
            psh  = bus.user_write_buffer && (m_q.size() < DEPTH);
            if (acc) begin
                rec.push_back({m_addr, m_q[0]});
                void'(m_q.pop_front());
                m_rem = m_rem - LW'(2);
                if (!m_fix)
                    m_addr = m_addr + AW'(2);
            end
            if (psh)
                m_q.push_back(bus.user_buffer_input_data);
            if (idle && bus.control_go && bus.control_write_length != 0) begin
                m_rem  = bus.control_write_length;
                m_addr = bus.control_write_base;
                m_fix  = bus.control_fixed_location;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.user_write_buffer      = 1'b1;
        bus.user_buffer_input_data = d;
        step();
        bus.user_write_buffer      = 1'b0;
    endtask

    task automatic go(input logic [AW-1:0] base, input logic [LW-1:0] len,
                      input logic fixed);
        bus.control_go             = 1'b1;
        bus.control_write_base     = base;
        bus.control_write_length   = len;
        bus.control_fixed_location = fixed;
        step();
        bus.control_go             = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!bus.control_done && k < budget) begin
            step();
            k++;
        end
        chk(tag, 64'(bus.control_done), 64'(1'b1));
    endtask

    logic [DW-1:0]    words [DEPTH+1];
    logic [AW+DW-1:0] e;

    initial begin
        reset                      = 1'b1;
        bus.control_go             = 1'b0;
        bus.control_fixed_location = 1'b0;
        bus.control_write_base     = '0;
        bus.control_write_length   = '0;
        bus.user_write_buffer      = 1'b0;
        bus.user_buffer_input_data = '0;
        bus.master_waitrequest     = 1'b0;
        step(3);
        reset = 1'b0;
        step();
        chk("rst_done", 64'(bus.control_done), 64'(1'b1));
        chk("rst_write", 64'(bus.master_write), 64'(1'b0));
        chk("rst_full", 64'(bus.user_buffer_full), 64'(1'b0));
        chk("rst_be", 64'(bus.master_byteenable), 64'(2'b11));

        // basic transfer
        rec.delete();
        for (int i = 1; i <= 4; i++) push(DW'(16'h1111 * i));
        go(AW'(32'h100), LW'(8), 1'b0);
        wait_done(20, "basic_done");
        chk("basic_n", 64'(rec.size()), 64'(4));
        for (int i = 0; i < 4 && i < rec.size(); i++) begin
            e = {AW'(32'h100 + 2 * i), DW'(16'h1111 * (i + 1))};
            chk("basic_wr", 64'(rec[i]), 64'(e));
        end

        // waitrequest stall on the second word
        rec.delete();
        for (int i = 1; i <= 4; i++) push(DW'(16'h1111 * i));
        go(AW'(32'h100), LW'(8), 1'b0);
        step();
        bus.master_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_a", 64'(bus.master_address), 64'(32'h102));
            chk("stall_d", 64'(bus.master_writedata), 64'(16'h2222));
        end
        bus.master_waitrequest = 1'b0;
        wait_done(20, "stall_done");
        chk("stall_n", 64'(rec.size()), 64'(4));
        for (int i = 0; i < 4 && i < rec.size(); i++) begin
            e = {AW'(32'h100 + 2 * i), DW'(16'h1111 * (i + 1))};
            chk("stall_wr", 64'(rec[i]), 64'(e));
        end

        // fixed location with underrun, plus go ignored while running
        rec.delete();
        go(AW'(32'h200), LW'(6), 1'b1);
        chk("under_w", 64'(bus.master_write), 64'(1'b0));
        chk("under_done", 64'(bus.control_done), 64'(1'b0));
        go(AW'(32'h300), LW'(2), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4);
            push(DW'(16'hA000 + i));
        end
        wait_done(20, "fix_done");
        chk("fix_n", 64'(rec.size()), 64'(3));
        for (int i = 0; i < 3 && i < rec.size(); i++) begin
            e = {AW'(32'h200), DW'(16'hA000 + i)};
            chk("fix_wr", 64'(rec[i]), 64'(e));
        end

        // zero length request
        rec.delete();
        go(AW'(32'h400), LW'(0), 1'b0);
        chk("len0_done", 64'(bus.control_done), 64'(1'b1));
        step(2);
        chk("len0_n", 64'(rec.size()), 64'(0));

        // fill beyond capacity, then drain 64 bytes
        for (int i = 0; i <= DEPTH; i++) begin
            words[i] = DW'($urandom);
            push(words[i]);
            if (i == DEPTH - 2)
                chk("not_full", 64'(bus.user_buffer_full), 64'(1'b0));
            if (i >= DEPTH - 1)
                chk("full", 64'(bus.user_buffer_full), 64'(1'b1));
        end
        go(AW'(32'h1000), LW'(64), 1'b0);
        wait_done(200, "full_done");
        chk("full_n", 64'(rec.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < rec.size(); i++) begin
            e = {AW'(32'h1000 + 2 * i), words[i]};
            chk("full_wr", 64'(rec[i]), 64'(e));
        end
        chk("drained", 64'(bus.user_buffer_full), 64'(1'b0));

        // reset in the middle of a transfer
        for (int i = 1; i <= 4; i++) push(DW'(16'h5000 + i));
        go(AW'(32'h800), LW'(8), 1'b0);
        step(2);
        chk("mid_w", 64'(bus.master_write), 64'(1'b1));
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_w", 64'(bus.master_write), 64'(1'b0));
        chk("rst_mid_done", 64'(bus.control_done), 64'(1'b1));
        chk("rst_mid_full", 64'(bus.user_buffer_full), 64'(1'b0));
        step(2);
        reset = 1'b0;
        step();
        rec.delete();
        push(DW'(16'hBEEF));
        go(AW'(32'h10), LW'(2), 1'b0);
        wait_done(20, "post_rst_done");
        chk("post_rst_n", 64'(rec.size()), 64'(1));
        if (rec.size() != 0)
            chk("post_rst_wr", 64'(rec[0]), 64'({AW'(32'h10), DW'(16'hBEEF)}));

        // randomized transfers with random pushes and stalls
        for (int t = 0; t < 8; t++) begin
            int k;
            go(AW'($urandom) & ~AW'(1), LW'(2 * $urandom_range(1, 10)),
               1'($urandom_range(0, 1)));
            k = 0;
            while (!bus.control_done && k < 400) begin
                bus.user_write_buffer      = 1'($urandom_range(0, 1));
                bus.user_buffer_input_data = DW'($urandom);
                bus.master_waitrequest     = ($urandom_range(0, 3) == 0);
                step();
                k++;
            end
            bus.user_write_buffer  = 1'b0;
            bus.master_waitrequest = 1'b0;
            chk("rand_done", 64'(bus.control_done), 64'(1'b1));
            step(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
